// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes on both sides, iterative one-bit-per-cycle
// shifts, and a full flag set (carry, zero, negative, overflow, illegal opcode).
module alu_seq #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned OP_W    = 6,
  parameter int unsigned SHAMT_W = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] rdo,
  output logic              carry,
  output logic              zero,
  output logic              neg,
  output logic              ovf,
  output logic              illegal
);

  localparam int unsigned MSB = DATA_W - 1;

  localparam logic [OP_W-1:0] OP_ADD = OP_W'(6'b100000);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(6'b100010);
  localparam logic [OP_W-1:0] OP_AND = OP_W'(6'b100100);
  localparam logic [OP_W-1:0] OP_OR  = OP_W'(6'b100101);
  localparam logic [OP_W-1:0] OP_XOR = OP_W'(6'b100110);
  localparam logic [OP_W-1:0] OP_NOR = OP_W'(6'b100111);
  localparam logic [OP_W-1:0] OP_SRL = OP_W'(6'b000010);
  localparam logic [OP_W-1:0] OP_SRA = OP_W'(6'b000011);
  localparam logic [OP_W-1:0] OP_SLL = OP_W'(6'b000000);

  // Shift kind is the low two opcode bits: 00 SLL, 10 SRL, 11 SRA
  localparam logic [1:0] SK_SLL = 2'b00;
  localparam logic [1:0] SK_SRL = 2'b10;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t               state;
  logic [DATA_W-1:0]    work;
  logic [SHAMT_W-1:0]   cnt;
  logic [1:0]           kind;

  logic [DATA_W:0]      sum_c;
  logic [DATA_W:0]      diff_c;
  logic [DATA_W-1:0]    res_c;
  logic                 cy_c;
  logic                 ov_c;
  logic                 ill_c;
  logic                 is_shift_c;
  logic [SHAMT_W-1:0]   shamt_c;
  logic [DATA_W-1:0]    step_w_c;
  logic                 step_cy_c;

  // Single-cycle result for everything that does not need the shifter
  always_comb begin
    sum_c      = {1'b0, a} + {1'b0, b};
    diff_c     = {1'b0, a} - {1'b0, b};
    shamt_c    = b[SHAMT_W-1:0];
    res_c      = '0;
    cy_c       = 1'b0;
    ov_c       = 1'b0;
    ill_c      = 1'b0;
    is_shift_c = 1'b0;
    case (op)
      OP_ADD: begin
        res_c = sum_c[DATA_W-1:0];
        cy_c  = sum_c[DATA_W];
        ov_c  = (a[MSB] == b[MSB]) & (res_c[MSB] != a[MSB]);
      end
      OP_SUB: begin
        res_c = diff_c[DATA_W-1:0];
        cy_c  = diff_c[DATA_W];
        ov_c  = (a[MSB] != b[MSB]) & (res_c[MSB] != a[MSB]);
      end
      OP_AND: res_c = a & b;
      OP_OR:  res_c = a | b;
      OP_XOR: res_c = a ^ b;
      OP_NOR: res_c = ~(a | b);
      OP_SRL, OP_SRA, OP_SLL: begin
        is_shift_c = 1'b1;
        res_c      = a;
      end
      default: ill_c = 1'b1;
    endcase
  end

  // One-bit shift step of the working register
  always_comb begin
    step_w_c  = {work[MSB], work[DATA_W-1:1]};
    step_cy_c = work[0];
    if (kind == SK_SLL) begin
      step_w_c  = {work[DATA_W-2:0], 1'b0};
      step_cy_c = work[MSB];
    end else if (kind == SK_SRL) begin
      step_w_c  = {1'b0, work[DATA_W-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      rdo       <= '0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
      ovf       <= 1'b0;
      illegal   <= 1'b0;
      work      <= '0;
      cnt       <= '0;
      kind      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (is_shift_c && (shamt_c != '0)) begin
              work  <= a;
              cnt   <= shamt_c;
              kind  <= op[1:0];
              state <= SHIFT;
            end else begin
              rdo       <= res_c;
              carry     <= cy_c;
              zero      <= (res_c == '0);
              neg       <= res_c[MSB];
              ovf       <= ov_c;
              illegal   <= ill_c;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        SHIFT: begin
          work <= step_w_c;
          cnt  <= cnt - SHAMT_W'(1);
          if (cnt == SHAMT_W'(1)) begin
            rdo       <= step_w_c;
            carry     <= step_cy_c;
            zero      <= (step_w_c == '0);
            neg       <= step_w_c[MSB];
            ovf       <= 1'b0;
            illegal   <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: flags, shift latency, backpressure, reset mid-shift, and illegal opcodes.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [5:0] op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] rdo;
  logic       carry, zero, neg, ovf, illegal;

  int checks = 0;
  int errors = 0;

  localparam logic [5:0] ADD = 6'b100000, SUB = 6'b100010, ANDO = 6'b100100,
                         ORO = 6'b100101, XORO = 6'b100110, SRL = 6'b000010,
                         SRA = 6'b000011, SLL = 6'b000000, BAD = 6'b111111;

  always #5 clk = ~clk;

  alu_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .rdo(rdo), .carry(carry), .zero(zero), .neg(neg), .ovf(ovf), .illegal(illegal)
  );

  // {out_valid, rdo, carry, zero, neg, ovf, illegal}
  function automatic logic [13:0] obs();
    return {out_valid, rdo, carry, zero, neg, ovf, illegal};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op and return #1 after the edge at which it transfers
  task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic [5:0] top);
    int n;
    n = 0;
    a = ta; b = tb; op = top; in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready: in_ready=%b required 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
    tick(); tick();
    checks++;
    if ({in_ready, obs()} !== {1'b1, 14'h0}) begin
      errors++;
      $display("FAIL reset: got %h required %h", {in_ready, obs()}, {1'b1, 14'h0});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_arith();
    send(8'hFF, 8'h01, ADD);
    checks++;
    if (obs() !== {1'b1, 8'h00, 5'b11000}) begin
      errors++;
      $display("FAIL add_carry: got %h required %h", obs(), {1'b1, 8'h00, 5'b11000});
    end
    drain();
    send(8'h05, 8'h07, SUB);
    checks++;
    if (obs() !== {1'b1, 8'hFE, 5'b10100}) begin
      errors++;
      $display("FAIL sub_borrow: got %h required %h", obs(), {1'b1, 8'hFE, 5'b10100});
    end
    drain();
    send(8'h7F, 8'h01, ADD);
    checks++;
    if (obs() !== {1'b1, 8'h80, 5'b00110}) begin
      errors++;
      $display("FAIL add_ovf: got %h required %h", obs(), {1'b1, 8'h80, 5'b00110});
    end
    drain();
  endtask

  task automatic test_shift();
    int cyc;
    send(8'h94, 8'h03, SRA);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({out_valid, in_ready} !== 2'b00) begin
        errors++;
        $display("FAIL sra_busy[%0d]: out_valid,in_ready=%b required 00", i, {out_valid, in_ready});
      end
      tick();
    end
    checks++;
    if ({in_ready, obs()} !== {1'b0, 1'b1, 8'hF2, 5'b10100}) begin
      errors++;
      $display("FAIL sra_result: got %h required %h", {in_ready, obs()}, {1'b0, 1'b1, 8'hF2, 5'b10100});
    end
    drain();
    send(8'h94, 8'h03, SRL);
    wait_valid(cyc);
    checks++;
    if ({cyc, obs()} !== {32'd3, 1'b1, 8'h12, 5'b10000}) begin
      errors++;
      $display("FAIL srl_result: cycles=%0d got %h required cycles=3 %h", cyc, obs(), {1'b1, 8'h12, 5'b10000});
    end
    drain();
    send(8'h81, 8'h01, SLL);
    wait_valid(cyc);
    checks++;
    if ({cyc, obs()} !== {32'd1, 1'b1, 8'h02, 5'b10000}) begin
      errors++;
      $display("FAIL sll_result: cycles=%0d got %h required cycles=1 %h", cyc, obs(), {1'b1, 8'h02, 5'b10000});
    end
    drain();
    // Amount field of zero: passthrough with single-cycle latency and no carry
    send(8'h85, 8'h08, SLL);
    checks++;
    if (obs() !== {1'b1, 8'h85, 5'b00100}) begin
      errors++;
      $display("FAIL sll_zero_amt: got %h required %h", obs(), {1'b1, 8'h85, 5'b00100});
    end
    drain();
  endtask

  task automatic test_backpressure();
    send(8'hF0, 8'h3C, ANDO);
    for (int i = 0; i < 5; i++) begin
      a = 8'hFF; b = 8'hFF; op = ORO; in_valid = (i % 2 == 0);
      tick();
      checks++;
      if ({out_valid, in_ready, rdo} !== {1'b1, 1'b0, 8'h30}) begin
        errors++;
        $display("FAIL hold[%0d]: got %h required %h", i, {out_valid, in_ready, rdo}, {1'b1, 1'b0, 8'h30});
      end
    end
    in_valid = 1'b0;
    drain();
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL release: in_ready,out_valid=%b required 10", {in_ready, out_valid});
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL no_ghost_op: out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_shift();
    send(8'h80, 8'h07, SRL);
    tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if ({in_ready, obs()} !== {1'b1, 14'h0}) begin
      errors++;
      $display("FAIL mid_shift_reset: got %h required %h", {in_ready, obs()}, {1'b1, 14'h0});
    end
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL discarded_op: out_valid=%b required 0", out_valid);
    end
    send(8'h0F, 8'hF0, ORO);
    checks++;
    if (obs() !== {1'b1, 8'hFF, 5'b00100}) begin
      errors++;
      $display("FAIL or_after_reset: got %h required %h", obs(), {1'b1, 8'hFF, 5'b00100});
    end
    drain();
  endtask

  task automatic test_illegal();
    send(8'h12, 8'h34, BAD);
    checks++;
    if (obs() !== {1'b1, 8'h00, 5'b01001}) begin
      errors++;
      $display("FAIL illegal_op: got %h required %h", obs(), {1'b1, 8'h00, 5'b01001});
    end
    drain();
    send(8'hAA, 8'hAA, XORO);
    checks++;
    if (obs() !== {1'b1, 8'h00, 5'b01000}) begin
      errors++;
      $display("FAIL xor_after_illegal: got %h required %h", obs(), {1'b1, 8'h00, 5'b01000});
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_arith();
    test_shift();
    test_backpressure();
    test_reset_mid_shift();
    test_illegal();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
